// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder with valid/ready handshakes on both sides.
// Multi-cycle ops (MUL/MULH) stay in EXEC for MUL_CYCLES-1 cycles before their code is presented.
module alu_ctrl_seq #(
    parameter int FUNCT_W    = 6,
    parameter int AOP_W      = 3,
    parameter int CTRL_W     = 4,
    parameter int MUL_CYCLES = 4,
    parameter int ERR_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [AOP_W-1:0]   aluop,
    input  logic [FUNCT_W-1:0] funct,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  alu_ctrl,
    output logic               multi_cycle,
    output logic               illegal,
    output logic               busy,
    output logic [ERR_W-1:0]   err_count
);

    localparam int CNT_W = $clog2(MUL_CYCLES);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, HOLD = 2'd2} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       dec_code;
    logic             dec_ill;
    logic             dec_mc;
    logic             accept;

    assign accept = in_valid && in_ready;

    // NOTE: every variable assigned in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        dec_code = 4'b1011;
        dec_ill  = 1'b1;
        dec_mc   = 1'b0;
        case (aluop)
            AOP_W'(0): begin
                dec_ill = 1'b0;
                case (funct)
                    FUNCT_W'(1): dec_code = 4'b0000;
                    FUNCT_W'(2): dec_code = 4'b0001;
                    FUNCT_W'(3): dec_code = 4'b0010;
                    default:     dec_ill  = 1'b1;
                endcase
            end
            AOP_W'(1): begin
                dec_ill = 1'b0;
                case (funct)
                    FUNCT_W'(1): dec_code = 4'b0011;
                    FUNCT_W'(2): dec_code = 4'b0100;
                    default:     dec_ill  = 1'b1;
                endcase
            end
            AOP_W'(2): begin
                dec_ill = 1'b0;
                case (funct)
                    FUNCT_W'(0): dec_code = 4'b0101;
                    FUNCT_W'(1): dec_code = 4'b0110;
                    FUNCT_W'(2): dec_code = 4'b1101;
                    FUNCT_W'(3): dec_code = 4'b1110;
                    FUNCT_W'(4): dec_code = 4'b0111;
                    FUNCT_W'(5): dec_code = 4'b1111;
                    default:     dec_ill  = 1'b1;
                endcase
            end
            AOP_W'(3): dec_ill = 1'b0;
            AOP_W'(4): begin
                dec_code = 4'b0000;
                dec_ill  = 1'b0;
            end
            AOP_W'(5): begin
                dec_code = 4'b0001;
                dec_ill  = 1'b0;
            end
            AOP_W'(6): begin
                if (funct == FUNCT_W'(0) || funct == FUNCT_W'(1)) begin
                    dec_code = (funct == FUNCT_W'(0)) ? 4'b1000 : 4'b1001;
                    dec_ill  = 1'b0;
                    dec_mc   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            state_nxt = dec_mc ? EXEC : HOLD;
        end else begin
            case (state)
                IDLE:    ;
                EXEC:    if (cnt == CNT_W'(1)) state_nxt = HOLD;
                HOLD:    if (out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // in_ready depends only on state and out_ready, never on in_valid.
    always_comb begin
        in_ready  = (state == IDLE) || (state == HOLD && out_ready);
        out_valid = (state == HOLD);
        busy      = (state == EXEC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_ctrl    <= CTRL_W'(4'b1011);
            multi_cycle <= 1'b0;
            illegal     <= 1'b0;
            cnt         <= '0;
            err_count   <= '0;
        end else begin
            if (accept) begin
                alu_ctrl    <= CTRL_W'(dec_code);
                multi_cycle <= dec_mc;
                illegal     <= dec_ill;
                cnt         <= dec_mc ? CNT_W'(MUL_CYCLES - 1) : '0;
            end else if (state == EXEC) begin
                cnt <= cnt - 1'b1;
            end
            if (accept && dec_ill && err_count != '1) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Registered, parametrised successor to the combinational ALU control decode. It accepts (aluop, funct) pairs over a valid/ready handshake, decodes them into an ALU control code, and holds the code stable for a programmable number of cycles for multi-cycle operations (MUL/MULH). It presents the result on a registered valid/ready output toward the execute stage. It sits between the main control unit and the ALU, replacing the pure decoder.

## Interface
- FUNCT_W, 6, width of funct field
- AOP_W, 3, width of aluop field
- CTRL_W, 4, width of ALU control code (must be ≥4)
- MUL_CYCLES, 4, cycles a multi-cycle op occupies the ALU (≥2)
- ERR_W, 8, width of saturating illegal-op counter

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  block can accept request this cycle
- aluop  in  AOP_W  ALU op class
- funct  in  FUNCT_W  function field
- out_valid  out  1  alu_ctrl valid for consumer
- out_ready  in  1  consumer accepts alu_ctrl
- alu_ctrl  out  CTRL_W  decoded ALU control code (registered)
- multi_cycle  out  1  current output is a multi-cycle op
- illegal  out  1  current output came from an undefined encoding
- busy  out  1  high in EXEC
- err_count  out  ERR_W  saturating count of accepted illegal requests

## Operation
- Decode (aluop/funct → code); any unlisted combination → 1011, illegal=1:
  - 000: funct 1→0000, 2→0001, 3→0010
  - 001: funct 1→0011, 2→0100
  - 010: funct 0→0101, 1→0110, 2→1101, 3→1110, 4→0111, 5→1111
  - 011 → 1011, illegal=0 (legal NOP); 100 → 0000; 101 → 0001 (funct ignored)
  - 110: funct 0→1000 (MUL), 1→1001 (MULH), multi_cycle=1
  - 111 → 1011, illegal=1
- Codes are zero-extended to CTRL_W.
- FSM states: IDLE, EXEC, HOLD.
  - IDLE: in_ready=1. On accept (in_valid&in_ready): register code/flags; if multi_cycle → EXEC with cnt=MUL_CYCLES-1, else → HOLD.
  - EXEC: in_ready=0, out_valid=0, busy=1, alu_ctrl holds the multi-cycle code. cnt decrements each cycle; at cnt==1 → HOLD.
  - HOLD: out_valid=1. in_ready=out_ready (single-entry pass-through). If out_ready and in_valid: load the new request (→HOLD or EXEC per its type). If out_ready and !in_valid → IDLE. If !out_ready: alu_ctrl, multi_cycle, illegal stable.
- err_count increments on each accepted illegal request; it saturates at all-ones and never wraps.
- Counter width is $clog2(MUL_CYCLES).

## Timing
- Reset values: state=IDLE, alu_ctrl=1011, out_valid=0, multi_cycle=0, illegal=0, busy=0, err_count=0; in_ready=1 after reset deasserts.
- Reset is effective immediately and asynchronously, including mid-EXEC or mid-HOLD. Any in-flight op is dropped and the counter is cleared.
- Single-cycle op accepted at edge N → out_valid=1 after edge N (visible in cycle N+1).
- Multi-cycle op accepted at edge N → busy cycles N+1..N+MUL_CYCLES-1 → out_valid in cycle N+MUL_CYCLES.
- Back-to-back single-cycle ops with out_ready=1 sustain one result per cycle.
- in_ready is combinational from state and out_ready only, never from in_valid.
- Simultaneous accept of an illegal request and saturation: err_count stays at max.

## Test plan
- Reset mid-EXEC: accept aluop=110/funct=0, assert rst in cycle 2 → all outputs at reset values immediately; first request after release decodes normally.
- Full decode sweep: every aluop×funct 0..63 with out_ready=1 → codes match the table; illegal=1 exactly for undefined pairs; err_count equals the count of illegal pairs (sat 255).
- Multi-cycle latency: MUL_CYCLES=4, accept 110/000001 at edge 0 → busy=1 in cycles 1–3, in_ready=0, out_valid=1 with alu_ctrl=1001 and multi_cycle=1 in cycle 4.
- Backpressure: accept 010/000011 with out_ready=0 for 5 cycles → alu_ctrl=1110 held, in_ready=0; release → handoff in one cycle; next request is accepted the same cycle.
- Streaming: 10 single-cycle requests with in_valid=out_ready=1 → 10 results on consecutive cycles, in order, no bubbles.
- Saturation: ERR_W=2, accept 5 requests of 111/0 → err_count sequence 1,2,3,3,3.
